// File: rtl/regbank_access_ctrl.sv
// Register-bank initiator: buffers one operand-read and one writeback request and
// sequences non-overlapping, gap-separated write_reg/read_reg strobes to the bank.
`timescale 1ns/1ps
module regbank_access_ctrl #(
    parameter int M = 16,
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [N-1:0] op_src1,
    input  logic [N-1:0] op_src2,
    output logic         opnd_valid,
    input  logic         opnd_ready,
    output logic [M:0]   opnd_1,
    output logic [M:0]   opnd_2,
    input  logic         wb_valid,
    output logic         wb_ready,
    input  logic [N-1:0] wb_addr,
    input  logic [M:0]   wb_data,
    output logic [N-1:0] addr_1,
    output logic [N-1:0] addr_2,
    output logic [N-1:0] end_write,
    output logic         write_reg,
    output logic         read_reg,
    output logic [M:0]   write_data,
    input  logic [M:0]   data_1,
    input  logic [M:0]   data_2
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WGAP = 3'd2,
        RD   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic         r_op_full;
    logic         r_wb_full;
    logic         r_write_reg;
    logic         r_read_reg;
    logic         r_opnd_valid;
    logic [N-1:0] r_addr_1;
    logic [N-1:0] r_addr_2;
    logic [N-1:0] r_end_write;
    logic [M:0]   r_write_data;
    logic [M:0]   r_opnd_1;
    logic [M:0]   r_opnd_2;
    logic         w_op_acc;
    logic         w_wb_acc;
    logic         w_resp_done;

    assign w_op_acc    = op_valid && !r_op_full;
    assign w_wb_acc    = wb_valid && !r_wb_full;
    assign w_resp_done = (r_state == RESP) && opnd_ready;

    // A buffered write always wins over a pending read.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (r_wb_full)
                    w_state_next = WR;
                else if (r_op_full)
                    w_state_next = RD;
            end
            WR:      w_state_next = WGAP;
            WGAP:    w_state_next = IDLE;
            RD:      w_state_next = RESP;
            RESP:    if (opnd_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Strobes and opnd_valid come straight from flops so the bank never sees decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_write_reg  <= 1'b0;
            r_read_reg   <= 1'b0;
            r_opnd_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_write_reg  <= (w_state_next == WR);
            r_read_reg   <= (w_state_next == RD);
            r_opnd_valid <= (w_state_next == RESP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_full    <= 1'b0;
            r_wb_full    <= 1'b0;
            r_addr_1     <= '0;
            r_addr_2     <= '0;
            r_end_write  <= '0;
            r_write_data <= '0;
            r_opnd_1     <= '0;
            r_opnd_2     <= '0;
        end else begin
            if (w_op_acc) begin
                r_op_full <= 1'b1;
                r_addr_1  <= op_src1;
                r_addr_2  <= op_src2;
            end else if (w_resp_done) begin
                r_op_full <= 1'b0;
            end
            if (w_wb_acc) begin
                r_wb_full    <= 1'b1;
                r_end_write  <= wb_addr;
                r_write_data <= wb_data;
            end else if (r_state == WR) begin
                r_wb_full <= 1'b0;
            end
            if (r_state == RD) begin
                r_opnd_1 <= data_1;
                r_opnd_2 <= data_2;
            end
        end
    end

    assign op_ready   = !r_op_full;
    assign wb_ready   = !r_wb_full;
    assign opnd_valid = r_opnd_valid;
    assign opnd_1     = r_opnd_1;
    assign opnd_2     = r_opnd_2;
    assign addr_1     = r_addr_1;
    assign addr_2     = r_addr_2;
    assign end_write  = r_end_write;
    assign write_data = r_write_data;
    assign write_reg  = r_write_reg;
    assign read_reg   = r_read_reg;

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// Bench for regbank_access_ctrl: behavioural bank, operand scoreboard, protocol monitor,
// directed latency/ordering/backpressure cases and a random phase.
`timescale 1ns/1ps
module tb_regbank_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid, op_ready, opnd_valid, opnd_ready;
    logic [4:0]  op_src1, op_src2, wb_addr, addr_1, addr_2, end_write;
    logic        wb_valid, wb_ready, write_reg, read_reg;
    logic [16:0] opnd_1, opnd_2, wb_data, write_data, data_1, data_2;

    int n_vec  = 0;
    int n_miss = 0;

    regbank_access_ctrl #(.M(16), .N(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_src1(op_src1), .op_src2(op_src2),
        .opnd_valid(opnd_valid), .opnd_ready(opnd_ready), .opnd_1(opnd_1), .opnd_2(opnd_2),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .addr_1(addr_1), .addr_2(addr_2), .end_write(end_write),
        .write_reg(write_reg), .read_reg(read_reg), .write_data(write_data),
        .data_1(data_1), .data_2(data_2)
    );

    always #5 clk = ~clk;

    // Behavioural bank
    logic [16:0] bank [0:31];
    assign data_1 = bank[addr_1];
    assign data_2 = bank[addr_2];
    always @(posedge clk) if (write_reg) bank[end_write] <= write_data;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference register contents and scoreboard
    logic [16:0] ref_mem [0:31];
    logic [9:0]  op_q [$];
    logic [33:0] sb_q [$];
    logic        pend_v;
    logic [4:0]  pend_a;
    logic [16:0] pend_d;
    logic        prev_wr, prev_rd, prev_ov, prev_ordy;
    logic [4:0]  prev_ew, prev_a1, prev_a2;
    logic [16:0] prev_wd, prev_o1, prev_o2;

    always @(negedge clk) begin
        if (!rst_n) begin
            op_q.delete();
            sb_q.delete();
            pend_v = 1'b0;
            prev_wr = 1'b0; prev_rd = 1'b0; prev_ov = 1'b0; prev_ordy = 1'b0;
        end else begin
            // A read sees every write accepted before the edge that started it.
            if (read_reg && !prev_rd) begin
                if (op_q.size() == 0) begin
                    check_eq("rd_without_op", read_reg, 1'b0);
                end else begin
                    logic [9:0] r;
                    r = op_q.pop_front();
                    sb_q.push_back({ref_mem[r[9:5]], ref_mem[r[4:0]]});
                end
            end
            if (pend_v) ref_mem[pend_a] = pend_d;
            pend_v = wb_valid && wb_ready;
            pend_a = wb_addr;
            pend_d = wb_data;
            if (op_valid && op_ready) op_q.push_back({op_src1, op_src2});

            if (opnd_valid && opnd_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_extra_opnd", opnd_valid, 1'b0);
                end else begin
                    logic [33:0] e;
                    e = sb_q.pop_front();
                    check_eq("sb_opnd_1", opnd_1, e[33:17]);
                    check_eq("sb_opnd_2", opnd_2, e[16:0]);
                end
            end

            if (write_reg || read_reg) begin
                check_eq("strobe_overlap", write_reg && read_reg, 1'b0);
                check_eq("strobe_pre_gap", prev_wr || prev_rd, 1'b0);
            end
            if (prev_wr) begin
                check_eq("wr_post_gap", write_reg || read_reg, 1'b0);
                check_eq("wr_addr_hold", end_write, prev_ew);
                check_eq("wr_data_hold", write_data, prev_wd);
            end
            if (prev_rd) check_eq("rd_post_gap", write_reg || read_reg, 1'b0);
            if (prev_rd || prev_ov) begin
                check_eq("rd_addr1_hold", addr_1, prev_a1);
                check_eq("rd_addr2_hold", addr_2, prev_a2);
            end
            if (prev_ov && !prev_ordy) begin
                check_eq("opnd_valid_hold", opnd_valid, 1'b1);
                check_eq("opnd_1_hold", opnd_1, prev_o1);
                check_eq("opnd_2_hold", opnd_2, prev_o2);
            end
            prev_wr = write_reg; prev_rd = read_reg; prev_ov = opnd_valid; prev_ordy = opnd_ready;
            prev_ew = end_write; prev_wd = write_data;
            prev_a1 = addr_1; prev_a2 = addr_2; prev_o1 = opnd_1; prev_o2 = opnd_2;
        end
    end

    // Drivers are called 1 ns after a rising edge and return 1 ns after the accepting edge.
    task automatic send_wb(input logic [4:0] a, input logic [16:0] d);
        int n = 0;
        wb_valid = 1'b1; wb_addr = a; wb_data = d;
        do begin @(negedge clk); n++; end while (!wb_ready && n < 50);
        check_eq("wb_accept_timeout", wb_ready, 1'b1);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        $display("wb   addr=%0d data=%05h", a, d);
    endtask

    task automatic send_op(input logic [4:0] s1, input logic [4:0] s2);
        int n = 0;
        op_valid = 1'b1; op_src1 = s1; op_src2 = s2;
        do begin @(negedge clk); n++; end while (!op_ready && n < 50);
        check_eq("op_accept_timeout", op_ready, 1'b1);
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic wait_opnd(output logic [16:0] o1, output logic [16:0] o2);
        int n = 0;
        do begin @(negedge clk); n++; end while (!opnd_valid && n < 50);
        check_eq("opnd_timeout", opnd_valid, 1'b1);
        o1 = opnd_1; o2 = opnd_2;
        @(posedge clk); #1;
    endtask

    task automatic read_op(input logic [4:0] s1, input logic [4:0] s2,
                           output logic [16:0] o1, output logic [16:0] o2);
        send_op(s1, s2);
        wait_opnd(o1, o2);
        $display("read src1=%0d src2=%0d -> %05h %05h", s1, s2, o1, o2);
    endtask

    initial begin
        logic [16:0] o1, o2;
        int w_first, r_first, n;
        for (int i = 0; i < 32; i++) begin bank[i] = '0; ref_mem[i] = '0; end
        rst_n = 1'b0; op_valid = 0; wb_valid = 0; opnd_ready = 1;
        op_src1 = 0; op_src2 = 0; wb_addr = 0; wb_data = 0;
        pend_v = 0; prev_wr = 0; prev_rd = 0; prev_ov = 0; prev_ordy = 0;
        #12;
        check_eq("rst_op_ready", op_ready, 1'b1);
        check_eq("rst_wb_ready", wb_ready, 1'b1);
        check_eq("rst_strobes", {write_reg, read_reg, opnd_valid}, 3'b000);
        check_eq("rst_opnd_1", opnd_1, 17'h0);
        check_eq("rst_end_write", end_write, 5'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: reset while read_reg is high
        op_valid = 1'b1; op_src1 = 5'd1; op_src2 = 5'd2;
        n = 0;
        do begin
            @(negedge clk); n++;
            if (op_ready) begin @(posedge clk); #1 op_valid = 1'b0; end
        end while (!read_reg && n < 20);
        check_eq("t1_rd_reached", read_reg, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t1_read_reg_async", read_reg, 1'b0);
        check_eq("t1_opnd_valid", opnd_valid, 1'b0);
        check_eq("t1_op_ready", op_ready, 1'b1);
        check_eq("t1_wb_ready", wb_ready, 1'b1);
        op_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t1_idle_after_rst", {write_reg, read_reg, opnd_valid}, 3'b000);
        end
        @(posedge clk); #1;
        $display("reset mid-read done");

        // 2: basic write then read, with exact latencies
        send_wb(5'd3, 17'h0ABCD);
        @(negedge clk); check_eq("t2_wr_e0", write_reg, 1'b0);
        @(negedge clk); check_eq("t2_wr_pulse", write_reg, 1'b1);
        check_eq("t2_end_write", end_write, 5'd3);
        check_eq("t2_write_data", write_data, 17'h0ABCD);
        @(negedge clk); check_eq("t2_wgap", write_reg, 1'b0);
        check_eq("t2_wb_ready_back", wb_ready, 1'b1);
        repeat (3) @(posedge clk); #1;
        send_op(5'd3, 5'd0);
        @(negedge clk); check_eq("t2_rd_e0", {read_reg, opnd_valid}, 2'b00);
        @(negedge clk); check_eq("t2_rd_pulse", {read_reg, opnd_valid}, 2'b10);
        @(negedge clk); check_eq("t2_opnd_valid_e2", {read_reg, opnd_valid}, 2'b01);
        check_eq("t2_opnd_1", opnd_1, 17'h0ABCD);
        check_eq("t2_opnd_2", opnd_2, 17'h0);
        $display("read src1=3 src2=0 -> %05h %05h", opnd_1, opnd_2);
        repeat (2) @(posedge clk); #1;

        // 3: simultaneous wb and op; write must go first
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 17'h1FFFF;
        op_valid = 1'b1; op_src1 = 5'd5; op_src2 = 5'd5;
        @(negedge clk);
        check_eq("t3_both_ready", {op_ready, wb_ready}, 2'b11);
        @(posedge clk); #1 wb_valid = 1'b0; op_valid = 1'b0;
        w_first = -1; r_first = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (write_reg && w_first < 0) w_first = i;
            if (read_reg && r_first < 0) r_first = i;
            if (opnd_valid) begin
                check_eq("t3_opnd_1", opnd_1, 17'h1FFFF);
                check_eq("t3_opnd_2", opnd_2, 17'h1FFFF);
            end
        end
        check_eq("t3_write_cycle", w_first, 1);
        check_eq("t3_read_cycle", r_first, 4);
        $display("simultaneous wb/op: write cycle %0d, read cycle %0d", w_first, r_first);
        @(posedge clk); #1;

        // 4: backpressure with a writeback arriving during RESP
        opnd_ready = 1'b0;
        send_op(5'd3, 5'd5);
        wait_opnd(o1, o2);
        send_wb(5'd7, 17'h01234);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t4_opnd_valid", opnd_valid, 1'b1);
            check_eq("t4_opnd_1", opnd_1, 17'h0ABCD);
            check_eq("t4_opnd_2", opnd_2, 17'h1FFFF);
            check_eq("t4_op_ready", op_ready, 1'b0);
            check_eq("t4_wb_ready", wb_ready, 1'b0);
            check_eq("t4_no_strobe", {write_reg, read_reg}, 2'b00);
        end
        @(posedge clk); #1 opnd_ready = 1'b1;
        @(negedge clk); check_eq("t4_hs_cycle", {opnd_valid, write_reg}, 2'b10);
        @(negedge clk); check_eq("t4_idle_cycle", {opnd_valid, write_reg}, 2'b00);
        @(negedge clk); check_eq("t4_wr_after_hs", write_reg, 1'b1);
        check_eq("t4_end_write", end_write, 5'd7);
        $display("backpressure released, deferred write addr=7");
        @(posedge clk); #1;

        // 5: back-to-back writes at both address extremes
        send_wb(5'd0, 17'h15555);
        send_wb(5'd31, 17'h0AAAA);
        read_op(5'd0, 5'd31, o1, o2);
        check_eq("t5_reg0", o1, 17'h15555);
        check_eq("t5_reg31", o2, 17'h0AAAA);
        read_op(5'd7, 5'd3, o1, o2);
        check_eq("t5_reg7", o1, 17'h01234);

        // 6: random traffic under the protocol monitor
        begin
            logic wacc, oacc;
            for (int c = 0; c < 1000; c++) begin
                @(negedge clk);
                wacc = wb_valid && wb_ready;
                oacc = op_valid && op_ready;
                if (wacc) $display("wb   addr=%0d data=%05h", wb_addr, wb_data);
                if (oacc) $display("op   src1=%0d src2=%0d", op_src1, op_src2);
                @(posedge clk); #1;
                if (!wb_valid || wacc) begin
                    wb_valid = ($urandom_range(0, 2) == 0);
                    wb_addr  = 5'($urandom);
                    wb_data  = 17'($urandom);
                end
                if (!op_valid || oacc) begin
                    op_valid = ($urandom_range(0, 2) == 0);
                    op_src1  = 5'($urandom);
                    op_src2  = 5'($urandom);
                end
                opnd_ready = ($urandom_range(0, 3) != 0);
            end
        end
        @(negedge clk);
        @(posedge clk); #1;
        wb_valid = 1'b0; op_valid = 1'b0; opnd_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_eq("sb_drained", sb_q.size(), 0);
        check_eq("op_q_drained", op_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
